// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory subsystem.
// Debug FSM encoding, I/O register offsets and address helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dbg_state_t;

  localparam logic [31:0] IO_OFF_OUT = 32'd0;
  localparam logic [31:0] IO_OFF_CYC = 32'd4;
  localparam logic [31:0] IO_OFF_CNT = 32'd8;

  function automatic logic [31:0] word_addr(
    input logic [31:0] ad
  );
    return {ad[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM: one synchronous write port, two async read ports.
// Contents are never reset.
module dmem_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dmem_subsystem.sv
// Data memory with memory-mapped I/O and a four-phase debug port.
// Define DMEM_CYCLE_CNT_EN to build the free-running cycle counter.
module dmem_subsystem
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 64,
  parameter int          IO_W    = 8,
  parameter logic [31:0] IO_BASE = 32'h0000_0400
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [31:0]     a,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [31:0]     dbg_addr,
  input  logic [31:0]     dbg_wdata,
  output logic            dbg_ack,
  output logic [31:0]     dbg_rdata,
  output logic [IO_W-1:0] io_out
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [31:0] A_OUT     = IO_BASE + IO_OFF_OUT;
  localparam logic [31:0] A_CYC     = IO_BASE + IO_OFF_CYC;
  localparam logic [31:0] A_CNT     = IO_BASE + IO_OFF_CNT;

  dbg_state_t  state;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] txn_cnt;
  logic [31:0] cyc_val;
  logic [31:0] io_ext;

  logic [31:0] core_w;
  logic [31:0] dbg_w;
  logic        core_ram;
  logic        dbg_ram;
  logic        dbg_go;
  logic        ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_core_rd;
  logic [31:0] ram_dbg_rd;
  logic [31:0] dbg_rd;

  assign core_w   = word_addr(a);
  assign dbg_w    = word_addr(lat_addr);
  assign core_ram = core_w < RAM_BYTES;
  assign dbg_ram  = dbg_w < RAM_BYTES;
  assign io_ext   = 32'(io_out);

  // Debug access only proceeds in a cycle the core leaves idle.
  assign dbg_go = (state == ST_WAIT) && !we && !reset;

  assign ram_we    = (we && core_ram)
                   || (dbg_go && lat_we && dbg_ram);
  assign ram_waddr = we ? a[AW+1:2] : lat_addr[AW+1:2];
  assign ram_wdata = we ? wd : lat_wdata;

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (a[AW+1:2]),
    .rdata_a (ram_core_rd),
    .raddr_b (lat_addr[AW+1:2]),
    .rdata_b (ram_dbg_rd)
  );

  function automatic logic [31:0] rmux(
    input logic [31:0] w,
    input logic [31:0] ramd,
    input logic [31:0] iod,
    input logic [31:0] cycd,
    input logic [31:0] cntd
  );
    logic [31:0] r;
    r = '0;
    unique case (1'b1)
      (w < RAM_BYTES): r = ramd;
      (w == A_OUT):    r = iod;
      (w == A_CYC):    r = cycd;
      (w == A_CNT):    r = cntd;
      default:         r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    rd = rmux(core_w, ram_core_rd, io_ext,
              cyc_val, txn_cnt);
  end

  always_comb begin
    dbg_rd = rmux(dbg_w, ram_dbg_rd, io_ext,
                  cyc_val, txn_cnt);
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (reset) cyc_cnt <= '0;
    else       cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign cyc_val = cyc_cnt;
`else
  assign cyc_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out <= '0;
    end else if (we && core_w == A_OUT) begin
      io_out <= wd[IO_W-1:0];
    end else if (dbg_go && lat_we && dbg_w == A_OUT) begin
      io_out <= lat_wdata[IO_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      txn_cnt   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (dbg_req) begin
            lat_we    <= dbg_we;
            lat_addr  <= dbg_addr;
            lat_wdata <= dbg_wdata;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!we) begin
            if (!lat_we) dbg_rdata <= dbg_rd;
            txn_cnt <= txn_cnt + 32'd1;
            dbg_ack <= 1'b1;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!dbg_req) begin
            dbg_ack <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          dbg_ack <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_subsystem.md
DMEM_SUBSYSTEM -- requirements
Module: dmem_subsystem

Interface
REQ-001 SHALL have parameter DEPTH, default 64: RAM depth in 32-bit words, power of two, 16..4096.
REQ-002 SHALL have parameter IO_W, default 8: io_out width, 1..32.
REQ-003 SHALL have parameter IO_BASE, default 32'h0000_0400: base byte address of the I/O region, 16-byte aligned, at or above DEPTH*4.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-006 SHALL have port we, input, 1: core write enable.
REQ-007 SHALL have port a, input, 32: core byte address.
REQ-008 SHALL have port wd, input, 32: core write data.
REQ-009 SHALL have port rd, output, 32: core read data, combinational from a.
REQ-010 SHALL have port dbg_req, input, 1: debug request, four-phase.
REQ-011 SHALL have port dbg_we, input, 1: debug write (1) or read (0).
REQ-012 SHALL have port dbg_addr, input, 32: debug byte address.
REQ-013 SHALL have port dbg_wdata, input, 32: debug write data.
REQ-014 SHALL have port dbg_ack, output, 1: debug acknowledge.
REQ-015 SHALL have port dbg_rdata, output, 32: registered debug read data.
REQ-016 SHALL have port io_out, output, IO_W: memory-mapped output register.

Function
REQ-017 SHALL decode addresses as word-aligned; a[1:0] is ignored.
REQ-018 SHALL map RAM at addresses below DEPTH*4.
REQ-019 SHALL map io_out at IO_BASE+0 (R/W; reads zero-extended; writes take wd[IO_W-1:0]).
REQ-020 SHALL map the cycle counter at IO_BASE+4 (read-only).
REQ-021 SHALL map the debug transaction count at IO_BASE+8 (read-only, 32-bit).
REQ-022 SHALL read 0 and ignore writes at all other addresses.
REQ-023 SHALL return rd combinationally in the same cycle as a, with zero latency.
REQ-024 SHALL perform a core write at the clk edge where we=1.
REQ-025 SHALL run the debug FSM with states IDLE, WAIT, ACK.
REQ-026 In IDLE with dbg_req=1, SHALL latch dbg_we, dbg_addr and dbg_wdata and go to WAIT.
REQ-027 In WAIT with we=0, SHALL perform the latched access, load dbg_rdata on a read (unchanged on a write), increment the transaction count and go to ACK.
REQ-028 In WAIT with we=1, SHALL stay in WAIT because the core has priority; there is no timeout.
REQ-029 In ACK, SHALL hold dbg_ack=1 until dbg_req=0, then go to IDLE; dbg_ack SHALL be 0 in all other states.
REQ-030 SHALL give 2-cycle minimum latency from dbg_req rise to dbg_ack rise.
REQ-031 When a core write and a debug write target the same word, the core write SHALL land first and the debug write later, so the debug value persists.
REQ-032 A debug read SHALL return the RAM contents as of the access cycle, including any core write from an earlier edge.
REQ-033 SHALL increment the cycle counter every cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-034 SHALL wrap the transaction count from 32'hFFFF_FFFF to 0.

Reset
REQ-035 SHALL clear io_out, dbg_rdata, dbg_ack, the cycle counter and the transaction count, and SHALL set the FSM to IDLE.
REQ-036 Reset in WAIT or ACK SHALL abort the transaction; a pending debug write SHALL be dropped; the requester SHALL re-issue after dropping dbg_req.
REQ-037 SHALL NOT reset RAM contents.

Configuration
REQ-038 With DMEM_CYCLE_CNT_EN defined, the cycle counter SHALL be implemented as in REQ-033.
REQ-039 Without DMEM_CYCLE_CNT_EN, no counter flops SHALL exist and IO_BASE+4 SHALL read 0.

Structure
REQ-040 Package dmem_pkg SHALL hold the FSM state encoding and the I/O offset constants (0, 4, 8).
REQ-041 SHALL contain one sub-module, dmem_ram: DEPTH x 32, one synchronous write port, two asynchronous read ports (core, debug).

Verification
REQ-042 Reset, then core write 32'hDEADBEEF at 0x10, then read 0x10 -> rd=32'hDEADBEEF in the same cycle.
REQ-043 Core write 32'h1A5 to IO_BASE -> io_out=8'hA5; read IO_BASE -> rd=32'h000000A5; read IO_BASE+12 -> 0.
REQ-044 Debug read 0x10 while we=0 -> dbg_ack rises 2 cycles after dbg_req with dbg_rdata=32'hDEADBEEF; count at IO_BASE+8 = 1.
REQ-045 Hold we=1 at 0x20 (data 32'h1111) for 5 cycles while a debug write of 32'h2222 to 0x20 is pending -> dbg_ack no earlier than cycle 6; final RAM[0x20]=32'h2222.
REQ-046 Assert reset in WAIT -> dbg_ack stays 0, RAM unchanged, FSM IDLE, count 0.
REQ-047 With DMEM_CYCLE_CNT_EN, read IO_BASE+4 N cycles after reset -> N; force the counter to 32'hFFFF_FFFF -> reads 0 next cycle; without the macro -> always 0.
